// File: rtl/scc_bus_seq.sv
// Z8530 SCC bus sequencer: splits a channel/register request into WR0 pointer + data accesses
// with registered strobes. Define SCC_INTACK_EN to add the interrupt-acknowledge cycle.
module scc_bus_seq #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int RECOV_CYC  = 6,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       we,
  input  logic       chan_a,
  input  logic       data_sel,
  input  logic [3:0] reg_sel,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       scc_ce_n,
  output logic       scc_rd_n,
  output logic       scc_wr_n,
  output logic       scc_ab_n,
  output logic       scc_dc_n,
  output logic [7:0] scc_d_out,
  output logic       scc_d_oe,
  input  logic [7:0] scc_d_in
`ifdef SCC_INTACK_EN
  ,
  input  logic       iack_req,
  output logic       iack_ack,
  output logic       scc_inta_n
`endif
);

  localparam int S = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
  localparam int T = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
  localparam int R = (RECOV_CYC  < 1) ? 1 : RECOV_CYC;
  localparam logic [CNT_W-1:0] S_LD = CNT_W'(S - 1);
  localparam logic [CNT_W-1:0] T_LD = CNT_W'(T - 1);
  localparam logic [CNT_W-1:0] R_LD = CNT_W'(R - 1);

  typedef enum logic [3:0] {
    IDLE, P_SETUP, P_STROBE, P_RECOV, D_SETUP, D_STROBE, D_RECOV, DONE
`ifdef SCC_INTACK_EN
    , I_SETUP, I_STROBE
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc;
  logic             we_q, chan_q, dsel_q;
  logic [3:0]       reg_q;
  logic [7:0]       wdata_q;
`ifdef SCC_INTACK_EN
  logic             iack_q;
  logic             iack_ack_d, inta_n_d;
`endif

  logic             eff_we, eff_chan, eff_dsel;
  logic [3:0]       eff_reg;
  logic [7:0]       eff_wdata, ptr;

  logic             ack_d, busy_d, ce_n_d, rd_n_d, wr_n_d, ab_n_d, dc_n_d, d_oe_d;
  logic [7:0]       d_out_d, rdata_d;

  assign tc = (cnt_q == '0);

  // Outputs are registered from next state, so the accept cycle must see the live request fields.
  assign eff_we    = (state_q == IDLE) ? we       : we_q;
  assign eff_chan  = (state_q == IDLE) ? chan_a   : chan_q;
  assign eff_dsel  = (state_q == IDLE) ? data_sel : dsel_q;
  assign eff_reg   = (state_q == IDLE) ? reg_sel  : reg_q;
  assign eff_wdata = (state_q == IDLE) ? wdata    : wdata_q;
  assign ptr       = eff_reg[3] ? {5'b00001, eff_reg[2:0]} : {5'b00000, eff_reg[2:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      chan_q  <= 1'b0;
      dsel_q  <= 1'b0;
      reg_q   <= '0;
      wdata_q <= '0;
`ifdef SCC_INTACK_EN
      iack_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && state_d != IDLE) begin
        we_q    <= we;
        chan_q  <= chan_a;
        dsel_q  <= data_sel;
        reg_q   <= reg_sel;
        wdata_q <= wdata;
`ifdef SCC_INTACK_EN
        iack_q  <= iack_req;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tc ? cnt_q : cnt_q - CNT_W'(1);
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
`ifdef SCC_INTACK_EN
        if (iack_req) begin
          state_d = I_SETUP;
          cnt_d   = S_LD;
        end else
`endif
        if (req) begin
          state_d = (!data_sel && reg_sel != 4'd0) ? P_SETUP : D_SETUP;
          cnt_d   = S_LD;
        end
      end
      P_SETUP:  if (tc) begin state_d = P_STROBE; cnt_d = T_LD; end
      P_STROBE: if (tc) begin state_d = P_RECOV;  cnt_d = R_LD; end
      P_RECOV:  if (tc) begin state_d = D_SETUP;  cnt_d = S_LD; end
      D_SETUP:  if (tc) begin state_d = D_STROBE; cnt_d = T_LD; end
      D_STROBE: if (tc) begin state_d = D_RECOV;  cnt_d = R_LD; end
      D_RECOV:  if (tc) begin state_d = DONE;     cnt_d = '0;   end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
`ifdef SCC_INTACK_EN
      I_SETUP:  if (tc) begin state_d = I_STROBE; cnt_d = T_LD; end
      I_STROBE: if (tc) begin state_d = D_RECOV;  cnt_d = R_LD; end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_d  = (state_d != IDLE);
    ce_n_d  = !(state_d == P_STROBE || state_d == D_STROBE);
    wr_n_d  = !(state_d == P_STROBE || (state_d == D_STROBE && eff_we));
    rd_n_d  = !(state_d == D_STROBE && !eff_we);
    d_oe_d  = (state_d == P_SETUP || state_d == P_STROBE) ||
              ((state_d == D_SETUP || state_d == D_STROBE) && eff_we);
    d_out_d = scc_d_out;
    ab_n_d  = scc_ab_n;
    dc_n_d  = scc_dc_n;
    rdata_d = rdata;
    if (state_d == P_SETUP || state_d == P_STROBE)
      d_out_d = ptr;
    else if ((state_d == D_SETUP || state_d == D_STROBE) && eff_we)
      d_out_d = eff_wdata;
    // Address pins only move on entry to a setup phase.
    if (state_d == P_SETUP) begin
      ab_n_d = eff_chan;
      dc_n_d = 1'b0;
    end else if (state_d == D_SETUP) begin
      ab_n_d = eff_chan;
      dc_n_d = eff_dsel;
    end
    if (state_q == D_STROBE && !we_q && tc)
      rdata_d = scc_d_in;
`ifdef SCC_INTACK_EN
    ce_n_d     = ce_n_d & (state_d != I_STROBE);
    rd_n_d     = rd_n_d & (state_d != I_STROBE);
    inta_n_d   = !(state_d == I_SETUP || state_d == I_STROBE);
    ack_d      = (state_d == DONE) && !iack_q;
    iack_ack_d = (state_d == DONE) && iack_q;
    if (state_q == I_STROBE && tc)
      rdata_d = scc_d_in;
`else
    ack_d = (state_d == DONE);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack        <= 1'b0;
      busy       <= 1'b0;
      rdata      <= '0;
      scc_ce_n   <= 1'b1;
      scc_rd_n   <= 1'b1;
      scc_wr_n   <= 1'b1;
      scc_ab_n   <= 1'b1;
      scc_dc_n   <= 1'b1;
      scc_d_out  <= '0;
      scc_d_oe   <= 1'b0;
`ifdef SCC_INTACK_EN
      iack_ack   <= 1'b0;
      scc_inta_n <= 1'b1;
`endif
    end else begin
      ack        <= ack_d;
      busy       <= busy_d;
      rdata      <= rdata_d;
      scc_ce_n   <= ce_n_d;
      scc_rd_n   <= rd_n_d;
      scc_wr_n   <= wr_n_d;
      scc_ab_n   <= ab_n_d;
      scc_dc_n   <= dc_n_d;
      scc_d_out  <= d_out_d;
      scc_d_oe   <= d_oe_d;
`ifdef SCC_INTACK_EN
      iack_ack   <= iack_ack_d;
      scc_inta_n <= inta_n_d;
`endif
    end
  end

endmodule

// File: tb/tb_scc_bus_seq.sv
// Scoreboard bench for scc_bus_seq: stimulus queues expected strobe pulses and acks,
// monitors pop and compare them as the DUT produces them.
module tb_scc_bus_seq;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       req = 1'b0, we = 1'b0, chan_a = 1'b0, data_sel = 1'b0;
  logic [3:0] reg_sel = 4'd0;
  logic [7:0] wdata = 8'h00, scc_d_in = 8'h00;
  logic       ack, busy, scc_ce_n, scc_rd_n, scc_wr_n, scc_ab_n, scc_dc_n, scc_d_oe;
  logic [7:0] rdata, scc_d_out;
  logic       iack_s, inta_low;
`ifdef SCC_INTACK_EN
  logic       iack_req = 1'b0, iack_ack, scc_inta_n;
  assign iack_s   = iack_ack;
  assign inta_low = !scc_inta_n;
`else
  assign iack_s   = 1'b0;
  assign inta_low = 1'b0;
`endif

  scc_bus_seq dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .chan_a(chan_a),
    .data_sel(data_sel), .reg_sel(reg_sel), .wdata(wdata), .ack(ack), .rdata(rdata),
    .busy(busy), .scc_ce_n(scc_ce_n), .scc_rd_n(scc_rd_n), .scc_wr_n(scc_wr_n),
    .scc_ab_n(scc_ab_n), .scc_dc_n(scc_dc_n), .scc_d_out(scc_d_out),
    .scc_d_oe(scc_d_oe), .scc_d_in(scc_d_in)
`ifdef SCC_INTACK_EN
    , .iack_req(iack_req), .iack_ack(iack_ack), .scc_inta_n(scc_inta_n)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct packed {
    logic       rd;
    logic       oe;
    logic [7:0] d;
    logic       dc;
    logic       ab;
    logic [7:0] len;
    logic       stable;
  } strb_t;

  typedef struct {
    int         cyc;
    logic [7:0] rdata;
    logic       iack;
  } ack_t;

  strb_t exp_strb[$];
  ack_t  exp_ack[$];

  function automatic strb_t mk_strb(input logic rd_i, input logic oe_i, input logic [7:0] d_i,
                                    input logic dc_i, input logic ab_i);
    strb_t s;
    s.rd = rd_i; s.oe = oe_i; s.d = d_i; s.dc = dc_i; s.ab = ab_i;
    s.len = 8'd3; s.stable = 1'b1;
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ack(input int c, input logic [7:0] r, input logic i);
    ack_t a;
    a.cyc = c; a.rdata = r; a.iack = i;
    exp_ack.push_back(a);
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (!ack && n < 60) begin @(negedge clk); n++; end
    if (!ack) begin
      total++; bad++;
      $display("FAIL %s: ack not seen within 60 cycles", name);
    end
  endtask

  // One access with hand-computed pointer byte, ack latency and rdata.
  task automatic run_access(input logic v_we, input logic v_chan, input logic v_dsel,
                            input logic [3:0] v_rsel, input logic [7:0] v_wd,
                            input logic [7:0] v_din, input logic v_ind,
                            input logic [7:0] v_ptr, input int v_k, input logic [7:0] v_rd);
    @(negedge clk);
    we = v_we; chan_a = v_chan; data_sel = v_dsel; reg_sel = v_rsel;
    wdata = v_wd; scc_d_in = v_din; req = 1'b1;
    if (v_ind) exp_strb.push_back(mk_strb(1'b0, 1'b1, v_ptr, 1'b0, v_chan));
    exp_strb.push_back(mk_strb(!v_we, v_we, v_we ? v_wd : 8'h00, v_dsel, v_chan));
    push_ack(cyc + v_k, v_rd, 1'b0);
    wait_ack("access_ack");
    req = 1'b0;
  endtask

  ack_t a_mon;
  always @(negedge clk) begin
    if (reset_n && (ack || iack_s)) begin
      total++;
      if (exp_ack.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: cyc=%0d rdata=%h", cyc, rdata);
      end else begin
        a_mon = exp_ack.pop_front();
        if (a_mon.cyc != cyc || a_mon.rdata != rdata || a_mon.iack != iack_s) begin
          bad++;
          $display("FAIL ack: got cyc=%0d rdata=%h iack=%b expected cyc=%0d rdata=%h iack=%b",
                   cyc, rdata, iack_s, a_mon.cyc, a_mon.rdata, a_mon.iack);
        end
      end
    end
  end

  logic       in_pulse = 1'b0, have_prev = 1'b0, skip = 1'b0;
  logic       lo, okstb, p_ab, p_dc, p_oe;
  logic [7:0] dm, p_d;
  int         gap = 0;
  strb_t      cur, e_mon;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_pulse = 1'b0; have_prev = 1'b0; gap = 0;
    end else begin
      lo    = !scc_ce_n || !scc_rd_n || !scc_wr_n;
      dm    = scc_d_oe ? scc_d_out : 8'h00;
      okstb = !scc_ce_n && (scc_rd_n != scc_wr_n);
      if (lo && !in_pulse) begin
        if (have_prev) begin
          total++;
          if (gap < 6) begin
            bad++;
            $display("FAIL recovery_gap: got %0d idle cycles, need at least 6", gap);
          end
        end
        in_pulse = 1'b1;
        skip     = inta_low;
        cur.rd = !scc_rd_n; cur.oe = scc_d_oe; cur.d = dm;
        cur.dc = scc_dc_n;  cur.ab = scc_ab_n; cur.len = 8'd1;
        cur.stable = okstb && p_ab == scc_ab_n && p_dc == scc_dc_n &&
                     p_oe == scc_d_oe && p_d == dm;
      end else if (lo) begin
        cur.len    = cur.len + 8'd1;
        cur.stable = cur.stable && okstb && cur.rd == !scc_rd_n && cur.oe == scc_d_oe &&
                     cur.d == dm && cur.dc == scc_dc_n && cur.ab == scc_ab_n;
      end else if (in_pulse) begin
        in_pulse = 1'b0; have_prev = 1'b1; gap = 1;
        if (!skip) begin
          total++;
          if (exp_strb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: got %h", cur);
          end else begin
            e_mon = exp_strb.pop_front();
            if (e_mon !== cur) begin
              bad++;
              $display("FAIL strobe: got %h expected %h", cur, e_mon);
            end
          end
        end
      end else begin
        gap++;
      end
      p_ab = scc_ab_n; p_dc = scc_dc_n; p_oe = scc_d_oe; p_d = dm;
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ce_n", scc_ce_n, 1);
    chk("rst_rd_n", scc_rd_n, 1);
    chk("rst_wr_n", scc_wr_n, 1);
    chk("rst_d_oe", scc_d_oe, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_d_out", scc_d_out, 0);
    chk("rst_ab_n", scc_ab_n, 1);
    chk("rst_dc_n", scc_dc_n, 1);
`ifdef SCC_INTACK_EN
    chk("rst_inta_n", scc_inta_n, 1);
`endif
    #1 reset_n = 1'b1;

    //          we chan dsel reg    wdata  din    ind ptr    K   rdata
    run_access(1, 1,   0,   4'd9,  8'hC0, 8'h00, 1, 8'h09, 21, 8'h00);
    run_access(0, 0,   0,   4'd0,  8'h00, 8'h44, 0, 8'h00, 11, 8'h44);
    run_access(1, 1,   0,   4'd12, 8'h81, 8'h00, 1, 8'h0C, 21, 8'h44);
    run_access(0, 1,   0,   4'd3,  8'h00, 8'h77, 1, 8'h03, 21, 8'h77);
    run_access(1, 1,   1,   4'd0,  8'h5A, 8'h00, 0, 8'h00, 11, 8'h77);
    run_access(0, 0,   1,   4'd7,  8'h00, 8'h96, 0, 8'h00, 11, 8'h96);
    run_access(1, 0,   0,   4'd15, 8'h3C, 8'h00, 1, 8'h0F, 21, 8'h96);
    run_access(0, 1,   0,   4'd8,  8'h00, 8'hE1, 1, 8'h08, 21, 8'hE1);

    // Abort an indirect write while its pointer strobe is low.
    @(negedge clk);
    we = 1'b1; chan_a = 1'b1; data_sel = 1'b0; reg_sel = 4'd5; wdata = 8'h11; req = 1'b1;
    n = 0;
    while (scc_wr_n && n < 20) begin @(negedge clk); n++; end
    chk("reach_p_strobe", scc_wr_n, 0);
    #1 reset_n = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("abort_ce_n", scc_ce_n, 1);
    chk("abort_rd_n", scc_rd_n, 1);
    chk("abort_wr_n", scc_wr_n, 1);
    chk("abort_d_oe", scc_d_oe, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    #1 reset_n = 1'b1;
    run_access(0, 1, 1, 4'd0, 8'h00, 8'hA5, 0, 8'h00, 11, 8'hA5);

`ifdef SCC_INTACK_EN
    // INTA wins over a simultaneous write, which is then served.
    @(negedge clk);
    iack_req = 1'b1; req = 1'b1; we = 1'b1; chan_a = 1'b0; data_sel = 1'b1;
    reg_sel = 4'd0; wdata = 8'h21; scc_d_in = 8'h3E;
    push_ack(cyc + 11, 8'h3E, 1'b1);
    push_ack(cyc + 23, 8'h3E, 1'b0);
    exp_strb.push_back(mk_strb(1'b0, 1'b1, 8'h21, 1'b1, 1'b0));
    n = 0;
    while (!iack_ack && n < 60) begin @(negedge clk); n++; end
    chk("iack_seen", iack_ack, 1);
    iack_req = 1'b0;
    @(negedge clk);
    wait_ack("iack_then_req_ack");
    req = 1'b0;
`endif

    repeat (12) @(negedge clk);
    chk("strobe_queue_drained", exp_strb.size(), 0);
    chk("ack_queue_drained", exp_ack.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/scc_bus_seq.md
Name: scc_bus_seq

Overview:
- Sequences host register accesses onto the Z8530 SCC's asynchronous bus pins (CE_n, RD_n, WR_n, AB_n, DC_n, D).
- Turns a flat "channel + register number" request into the SCC's two-step access: a WR0 pointer write, then the data access.
- Enforces setup, strobe-width and inter-access recovery times in clk cycles.
- Sits between the Sun-2 bus-side decoder and the SCC pins; one requester, one access in flight.

Parameters:
- SETUP_CYC, 1, cycles AB_n/DC_n/D valid before strobe (values below 1 are treated as 1)
- STROBE_CYC, 3, cycles CE_n plus RD_n or WR_n held low (values below 1 are treated as 1)
- RECOV_CYC, 6, cycles all strobes high after each SCC access (values below 1 are treated as 1)
- CNT_W, 4, width of the phase counter; must hold max(SETUP_CYC, STROBE_CYC, RECOV_CYC)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- req  in  1  access request; held until ack
- we  in  1  1 = write, 0 = read
- chan_a  in  1  1 = channel A, 0 = channel B
- data_sel  in  1  1 = data register (DC_n high), 0 = control register
- reg_sel  in  4  control register number 0-15 (ignored when data_sel = 1)
- wdata  in  8  write data
- ack  out  1  one-cycle completion pulse
- rdata  out  8  read data; valid while ack is high, held until the next capture
- busy  out  1  high whenever state is not IDLE
- scc_ce_n, scc_rd_n, scc_wr_n  out  1 each  SCC strobes
- scc_ab_n  out  1  high = channel A, low = channel B
- scc_dc_n  out  1  high = data, low = control
- scc_d_out  out  8  data driven to the SCC
- scc_d_oe  out  1  data bus output enable
- scc_d_in  in  8  data from the SCC

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to IDLE; this also aborts any in-flight access.
  - ce_n, rd_n and wr_n go high on that same edge.
  - d_oe = 0, ack = 0, busy = 0, rdata = 0, d_out = 0, ab_n = 1, dc_n = 1.
- All outputs are registered.
- States: IDLE, P_SETUP, P_STROBE, P_RECOV, D_SETUP, D_STROBE, D_RECOV, DONE.
- Accept:
  - A request is taken when req = 1 in IDLE; we, chan_a, data_sel, reg_sel and wdata are latched on that edge.
  - Indirect access (data_sel = 0 and reg_sel != 0) goes to P_SETUP.
  - Direct access (data_sel = 1, or reg_sel = 0) goes to D_SETUP and skips the pointer phase.
- Pointer phase:
  - dc_n = 0, ab_n from chan_a, d_oe = 1, WR strobe.
  - Pointer value: reg_sel < 8 gives {5'b00000, reg_sel[2:0]}; reg_sel >= 8 gives {2'b00, 3'b001, reg_sel[2:0]} (point-high command).
- Data phase:
  - dc_n = data_sel, ab_n from chan_a.
  - Write: d_oe = 1 for all of D_SETUP/D_STROBE; d_out = wdata.
  - Read: d_oe = 0; rdata samples scc_d_in on the last D_STROBE cycle.
- Phase timing:
  - Each *_SETUP phase lasts SETUP_CYC cycles with strobes high.
  - Each *_STROBE phase holds ce_n low together with rd_n (read) or wr_n (write, pointer) for STROBE_CYC cycles.
  - Each *_RECOV phase holds all strobes high and d_oe = 0 for RECOV_CYC cycles.
  - ab_n and dc_n do not change during strobe or recovery.
- Completion:
  - DONE lasts exactly 1 cycle with ack = 1, then returns to IDLE.
  - req is ignored during DONE; the requester drops req in the ack cycle.
- Latency:
  - ack is high in cycle K after the accept edge.
  - Direct: K = S+T+R+1 (11 at defaults). Indirect: K = 2(S+T+R)+1 (21 at defaults).
- Back-to-back requests: the earliest next accept is the cycle after DONE. Recovery is therefore always honoured between SCC accesses, including pointer to data.
- req dropped mid-access: the access still completes and ack still pulses.

Optional Feature:
- Macro: SCC_INTACK_EN.
- Defined: adds ports iack_req (in), iack_ack (out), scc_inta_n (out, reset 1) and states I_SETUP/I_STROBE.
  - iack_req in IDLE starts an interrupt-acknowledge cycle.
  - scc_inta_n is low for SETUP_CYC+STROBE_CYC cycles; rd_n and ce_n are low only during the STROBE_CYC part.
  - The vector is sampled into rdata on the last strobe cycle, then RECOV_CYC cycles, then iack_ack pulses for 1 cycle.
  - If req and iack_req are both high in IDLE, iack wins.
- Undefined: none of these ports or states exist; the INTA_n pin is tied high by the parent.

Test Plan:
- Write chan A, reg 9, wdata 0xC0, defaults -> pointer 0x09 then 0xC0; dc_n = 0 both phases, ab_n = 1; wr_n low 3 cycles each; ack at cycle 21.
- Read chan B, reg 0, scc_d_in = 0x44 -> no pointer phase; ab_n = 0, rd_n low 3 cycles, d_oe = 0; ack at cycle 11 with rdata = 0x44.
- Write reg 12 then read reg 3 back-to-back -> pointer bytes 0x0C and 0x03; at least 6 idle-strobe cycles between every pair of strobe pulses.
- Data-register write 0x5A, chan A -> dc_n = 1, single access, ack at cycle 11.
- reset_n low during P_STROBE -> next edge: all strobes high, d_oe = 0, busy = 0, no ack; a new request afterwards completes normally.
- With SCC_INTACK_EN: iack_req and req together, scc_d_in = 0x3E -> INTA cycle first; iack_ack with rdata = 0x3E; the pending req is then serviced.
